dram_device_model: RTL and testbench
====================================

Name: dram_device_model

Overview:
- Cycle-accurate DRAM device that sits directly downstream of the AXI DRAM wrapper.
- Consumes the wrapper's pin-level commands (DRAM_CSn/RASn/CASn/WEn/A/D) and returns DRAM_Q/DRAM_valid after a fixed CAS latency.
- Models an open-row bank with activate, read, byte-masked write and precharge.
- Used as the memory endpoint in system simulation.

Parameters:
- DATA_BITS, 32, data width; STRB_BITS = DATA_BITS/8.
- ROW_BITS, 11, row address width; A width = ROW_BITS.
- COL_BITS, 10, column address width, taken from A[COL_BITS-1:0].
- CAS_LATENCY, 5, cycles from READ command sample to DRAM_valid (≥1).
- T_RCD, 5, minimum cycles from ACT to READ/WRITE (checked only with the optional feature).
- T_RP, 5, minimum cycles from PRE to next ACT (checked only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- DRAM_CSn  in  1  chip select, active low
- DRAM_RASn  in  1  row strobe, active low
- DRAM_CASn  in  1  column strobe, active low
- DRAM_WEn  in  STRB_BITS  per-byte write enable, active low
- DRAM_A  in  ROW_BITS  row or column address
- DRAM_D  in  DATA_BITS  write data
- DRAM_Q  out  DATA_BITS  read data
- DRAM_valid  out  1  one-cycle read-data strobe
- row_open  out  1  a row is currently active
- cmd_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: DRAM_Q=0, DRAM_valid=0, row_open=0, cmd_err=0, open-row register=0, read pipe empty. Array contents are not reset.
- Command decode on posedge clk, only when CSn=0:
  - ACT: RASn=0, CASn=1, WEn all 1.
  - PRE: RASn=0, CASn=1, WEn all 0.
  - READ: RASn=1, CASn=0, WEn all 1.
  - WRITE: RASn=1, CASn=0, WEn not all 1.
  - NOP: CSn=1, or RASn=CASn=1.
  - Any other combination is illegal: set cmd_err, no other effect.
- State machine (2 states):
  - IDLE --ACT--> ACTIVE, latch row=A.
  - ACTIVE --PRE--> IDLE.
  - ACT while ACTIVE: cmd_err set, row unchanged.
  - PRE while IDLE: harmless no-op.
- WRITE in ACTIVE: at word {row, A[COL_BITS-1:0]}, each byte i is written from D when WEn[i]=0. Takes effect at that edge.
- READ in ACTIVE: array sampled at the command edge (read-before-later-write). The word enters a CAS_LATENCY-deep pipe.
  - DRAM_valid is high exactly CAS_LATENCY cycles after the command edge, for one cycle, with DRAM_Q = sampled word.
  - DRAM_Q holds its last value when DRAM_valid=0.
- READ/WRITE in IDLE: cmd_err set; no array access, no pipe entry.
- Back-to-back READs (one per cycle) must each return in order with no bubbles or loss.
- The read pipe keeps draining across PRE and ACT. Only reset clears it.
- cmd_err is cleared only by reset.
- Reset mid-operation: outputs are forced to reset values immediately (asynchronous) and in-flight reads are discarded.
- The column index truncates to COL_BITS. No wrap or carry into the row.

Optional Feature:
- Macro: DRAM_TIMING_CHECK_EN.
- Defined:
  - A counter is loaded on ACT and on PRE.
  - READ/WRITE issued fewer than T_RCD cycles after ACT is rejected: cmd_err set, no access.
  - ACT issued fewer than T_RP cycles after PRE is rejected: cmd_err set, row stays closed.
- Undefined: no timing counters; commands are honoured regardless of spacing.

Decomposition:
- Package dram_pkg holds:
  - enum dram_cmd_e {NOP, ACT, PRE, RD, WR, ILLEGAL};
  - state enum {IDLE, ACTIVE};
  - default width localparams.
- One sub-module, dram_rd_pipe: a CAS_LATENCY-deep valid+data shift register with async active-low reset.

Test Plan:
- Reset: hold rst=0 → Q=0, valid=0, row_open=0, cmd_err=0. Release, then 10 NOPs → valid stays 0.
- ACT A=0x12, then after 5 cycles WRITE A=0x034, WEn=4'h0, D=0xDEADBEEF, then READ A=0x034 → valid high exactly 5 cycles after the READ, Q=0xDEADBEEF, cmd_err=0.
- Byte mask: WRITE WEn=4'b1010, D=0x11223344 over 0xDEADBEEF, then READ → Q=0xDE22BE44.
- Four consecutive READs to columns 0–3 holding 0xA0..0xA3 → valid high on 4 consecutive cycles, Q=0xA0,0xA1,0xA2,0xA3.
- PRE, then READ → cmd_err=1, no valid pulse. ACT while a row is already open → cmd_err=1, row unchanged.
- With DRAM_TIMING_CHECK_EN: ACT then READ 2 cycles later → cmd_err=1, no valid. Without the macro, the same stimulus returns data and cmd_err stays 0.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared command/state encodings, default widths and the pin-level command decoder
// for the DRAM device model.
package dram_pkg;

    localparam int DEF_DATA_BITS   = 32;
    localparam int DEF_ROW_BITS    = 11;
    localparam int DEF_COL_BITS    = 10;
    localparam int DEF_CAS_LATENCY = 5;
    localparam int DEF_T_RCD       = 5;
    localparam int DEF_T_RP        = 5;
    localparam int TIMER_BITS      = 8;

    typedef enum logic [2:0] {NOP, ACT, PRE, RD, WR, ILLEGAL} dram_cmd_e;

    typedef enum logic [0:0] {IDLE, ACTIVE} dram_state_e;

    function automatic dram_cmd_e decode_cmd(
        input logic csn,
        input logic rasn,
        input logic casn,
        input logic we_all_hi,
        input logic we_all_lo
    );
        dram_cmd_e c;
        c = ILLEGAL;
        if (csn) begin
            c = NOP;
        end else begin
            case ({rasn, casn})
                2'b11: c = NOP;
                2'b01: c = we_all_hi ? ACT : (we_all_lo ? PRE : ILLEGAL);
                2'b10: c = we_all_hi ? RD : WR;
                default: c = ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Fixed-depth read-return shift register: valid bits are cleared by reset,
// data stages simply follow along.
module dram_rd_pipe #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data
);

    logic [DEPTH-1:0]     vld;
    logic [DATA_BITS-1:0] dat [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/dram_device_model.sv
// Cycle-accurate single-bank open-row DRAM endpoint with CAS-latency read return.
// Define DRAM_TIMING_CHECK_EN to reject commands violating tRCD / tRP.
module dram_device_model
    import dram_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int STRB_BITS   = DATA_BITS / 8,
    parameter int ROW_BITS    = DEF_ROW_BITS,
    parameter int COL_BITS    = DEF_COL_BITS,
    parameter int CAS_LATENCY = DEF_CAS_LATENCY,
    parameter int T_RCD       = DEF_T_RCD,
    parameter int T_RP        = DEF_T_RP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 DRAM_CSn,
    input  logic                 DRAM_RASn,
    input  logic                 DRAM_CASn,
    input  logic [STRB_BITS-1:0] DRAM_WEn,
    input  logic [ROW_BITS-1:0]  DRAM_A,
    input  logic [DATA_BITS-1:0] DRAM_D,
    output logic [DATA_BITS-1:0] DRAM_Q,
    output logic                 DRAM_valid,
    output logic                 row_open,
    output logic                 cmd_err
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int WORDS     = 1 << ADDR_BITS;

    dram_cmd_e             cmd;
    dram_state_e           state;
    logic [ROW_BITS-1:0]   row;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_BITS-1:0]  mem [WORDS];
    logic [DATA_BITS-1:0]  rd_word;
    logic                  act_ok, pre_ok, rd_ok, wr_ok, err_now;
    logic                  act_ready, rw_ready;
    logic                  pipe_valid;
    logic [DATA_BITS-1:0]  pipe_data;

    always_comb begin
        cmd = decode_cmd(DRAM_CSn, DRAM_RASn, DRAM_CASn, &DRAM_WEn, ~|DRAM_WEn);
    end

`ifdef DRAM_TIMING_CHECK_EN
    logic [TIMER_BITS-1:0] timer;

    // Loaded with spacing-1 so the command exactly T cycles later sees zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (act_ok) begin
            timer <= TIMER_BITS'(T_RCD - 1);
        end else if (pre_ok) begin
            timer <= TIMER_BITS'(T_RP - 1);
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign act_ready = (timer == '0);
    assign rw_ready  = (timer == '0);
`else
    assign act_ready = 1'b1;
    assign rw_ready  = 1'b1;
`endif

    always_comb begin
        act_ok  = (cmd == ACT) && (state == IDLE) && act_ready;
        pre_ok  = (cmd == PRE) && (state == ACTIVE);
        rd_ok   = (cmd == RD) && (state == ACTIVE) && rw_ready;
        wr_ok   = (cmd == WR) && (state == ACTIVE) && rw_ready;
        err_now = (cmd == ILLEGAL)
                || ((cmd == ACT) && !act_ok)
                || ((cmd == RD) && !rd_ok)
                || ((cmd == WR) && !wr_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row      <= '0;
            row_open <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            if (act_ok) begin
                state    <= ACTIVE;
                row      <= DRAM_A;
                row_open <= 1'b1;
            end else if (pre_ok) begin
                state    <= IDLE;
                row_open <= 1'b0;
            end
            if (err_now) begin
                cmd_err <= 1'b1;
            end
        end
    end

    assign addr    = {row, DRAM_A[COL_BITS-1:0]};
    assign rd_word = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int unsigned i = 0; i < STRB_BITS; i++) begin
                if (!DRAM_WEn[i]) begin
                    mem[addr][i*8 +: 8] <= DRAM_D[i*8 +: 8];
                end
            end
        end
    end

    dram_rd_pipe #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (CAS_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_ok),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DRAM_valid <= 1'b0;
            DRAM_Q     <= '0;
        end else begin
            DRAM_valid <= pipe_valid;
            if (pipe_valid) begin
                DRAM_Q <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_dram_device_model.sv
// Directed self-checking bench for dram_device_model (default build, or with
// DRAM_TIMING_CHECK_EN defined for the timing-rejection case).
module tb_dram_device_model;

    localparam int CL = 5;

    logic        clk;
    logic        rst;
    logic        csn;
    logic        rasn;
    logic        casn;
    logic [3:0]  wen;
    logic [10:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        valid;
    logic        row_open;
    logic        cmd_err;

    int n_assert = 0;
    int n_fail   = 0;

    dram_device_model #(
        .DATA_BITS   (32),
        .ROW_BITS    (11),
        .COL_BITS    (10),
        .CAS_LATENCY (CL),
        .T_RCD       (5),
        .T_RP        (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .DRAM_CSn   (csn),
        .DRAM_RASn  (rasn),
        .DRAM_CASn  (casn),
        .DRAM_WEn   (wen),
        .DRAM_A     (a),
        .DRAM_D     (d),
        .DRAM_Q     (q),
        .DRAM_valid (valid),
        .row_open   (row_open),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_nop();
        csn = 1'b1; rasn = 1'b1; casn = 1'b1; wen = 4'hF; a = '0; d = '0;
    endtask

    // Drive one command for one edge; returns at the following negedge.
    task automatic issue(input logic c, input logic r, input logic s,
                         input logic [3:0] w, input logic [10:0] av, input logic [31:0] dv);
        csn = c; rasn = r; casn = s; wen = w; a = av; d = dv;
        @(posedge clk);
        @(negedge clk);
        set_nop();
    endtask

    task automatic act(input logic [10:0] av);  issue(1'b0, 1'b0, 1'b1, 4'hF, av, '0); endtask
    task automatic pre();                       issue(1'b0, 1'b0, 1'b1, 4'h0, '0, '0); endtask
    task automatic rd(input logic [10:0] av);   issue(1'b0, 1'b1, 1'b0, 4'hF, av, '0); endtask
    task automatic wr(input logic [10:0] av, input logic [3:0] w, input logic [31:0] dv);
        issue(1'b0, 1'b1, 1'b0, w, av, dv);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Called right after a READ edge: valid must rise exactly CL edges later.
    task automatic expect_read(input string tag, input logic [31:0] exp);
        for (int k = 1; k <= CL; k++) begin
            nop(1);
            if (k < CL) chk({tag, "_early"}, {31'b0, valid}, 32'd0);
        end
        chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
        chk({tag, "_q"}, q, exp);
        nop(1);
        chk({tag, "_drop"}, {31'b0, valid}, 32'd0);
        chk({tag, "_hold"}, q, exp);
    endtask

    task automatic expect_no_read(input string tag);
        for (int k = 1; k <= CL + 1; k++) begin
            nop(1);
            chk(tag, {31'b0, valid}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        set_nop();
        rst = 1'b0;
        #12;
        chk("rst_q", q, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_row_open", {31'b0, row_open}, 32'd0);
        chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nop(1);
            chk("idle_valid", {31'b0, valid}, 32'd0);
        end

        act(11'h012);
        chk("act_row_open", {31'b0, row_open}, 32'd1);
        nop(4);
        wr(11'h034, 4'h0, 32'hDEADBEEF);
        rd(11'h034);
        expect_read("full_wr", 32'hDEADBEEF);
        chk("full_wr_err", {31'b0, cmd_err}, 32'd0);

        wr(11'h034, 4'b1010, 32'h11223344);
        rd(11'h034);
        expect_read("byte_mask", 32'hDE22BE44);

        wr(11'h000, 4'h0, 32'h000000A0);
        wr(11'h001, 4'h0, 32'h000000A1);
        wr(11'h002, 4'h0, 32'h000000A2);
        wr(11'h003, 4'h0, 32'h000000A3);
        wr(11'h405, 4'h0, 32'h00000055);
        rd(11'h000);
        rd(11'h001);
        rd(11'h002);
        rd(11'h003);
        nop(1);
        chk("burst_gap", {31'b0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nop(1);
            chk("burst_valid", {31'b0, valid}, 32'd1);
            chk("burst_q", q, 32'h000000A0 + 32'(i));
        end
        nop(1);
        chk("burst_end", {31'b0, valid}, 32'd0);

        rd(11'h005);
        expect_read("col_trunc", 32'h00000055);

        wr(11'h007, 4'h0, 32'h00000077);
        rd(11'h007);
        wr(11'h007, 4'h0, 32'h00000088);
        for (int i = 0; i < 3; i++) begin
            nop(1);
            chk("rbw_early", {31'b0, valid}, 32'd0);
        end
        nop(1);
        chk("rbw_valid", {31'b0, valid}, 32'd1);
        chk("rbw_old_data", q, 32'h00000077);
        rd(11'h007);
        expect_read("rbw_new", 32'h00000088);

        rd(11'h000);
        pre();
        chk("pre_row_open", {31'b0, row_open}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            nop(1);
            chk("drain_early", {31'b0, valid}, 32'd0);
        end
        nop(1);
        chk("drain_valid", {31'b0, valid}, 32'd1);
        chk("drain_q", q, 32'h000000A0);
        chk("drain_err", {31'b0, cmd_err}, 32'd0);

        pre();
        chk("pre_idle_err", {31'b0, cmd_err}, 32'd0);

        rd(11'h034);
        chk("rd_idle_err", {31'b0, cmd_err}, 32'd1);
        expect_no_read("rd_idle_no_valid");

        act(11'h012);
        chk("reopen", {31'b0, row_open}, 32'd1);
        nop(5);
        act(11'h033);
        chk("act_active_err", {31'b0, cmd_err}, 32'd1);
        chk("act_active_open", {31'b0, row_open}, 32'd1);
        nop(5);
        rd(11'h034);
        expect_read("row_kept", 32'hDE22BE44);

        rd(11'h034);
        nop(2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_q", q, 32'd0);
        chk("async_valid", {31'b0, valid}, 32'd0);
        chk("async_row_open", {31'b0, row_open}, 32'd0);
        chk("async_err", {31'b0, cmd_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_no_read("flush");

        issue(1'b0, 1'b0, 1'b0, 4'hF, '0, '0);
        chk("illegal_err", {31'b0, cmd_err}, 32'd1);
        chk("illegal_row", {31'b0, row_open}, 32'd0);
        do_reset();
        chk("reset2_err", {31'b0, cmd_err}, 32'd0);

        act(11'h012);
        nop(1);
        rd(11'h034);
`ifdef DRAM_TIMING_CHECK_EN
        chk("trcd_err", {31'b0, cmd_err}, 32'd1);
        expect_no_read("trcd_no_valid");
`else
        chk("trcd_err", {31'b0, cmd_err}, 32'd0);
        expect_read("trcd_off", 32'hDE22BE44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
